prio_encoder_rr: RTL



---
 rtl/prio_encoder_rr_pkg.sv | 9 +
 rtl/prio_encoder_rr_if.sv | 30 +++
 rtl/prio_encoder_rr_find.sv | 40 ++++
 rtl/prio_encoder_rr.sv | 79 +++++++
 4 files changed

// File: rtl/prio_encoder_rr_pkg.sv
// prio_encoder_rr_pkg: shared constants for the registered priority encoder.
//   PRIO_FIXED - highest set bit wins
//   PRIO_RR    - round-robin search starting at a rotating pointer
package prio_encoder_rr_pkg;

  localparam int unsigned PRIO_FIXED = 0;
  localparam int unsigned PRIO_RR    = 1;

endpackage

// File: rtl/prio_encoder_rr_if.sv
// prio_encoder_rr_if: input and output valid/ready streams of prio_encoder_rr.
//   in_valid/in_ready/din            - request vector stream into the encoder
//   out_valid/out_ready/dout/none/multi - encoded result stream out of the encoder
//   master: producer/consumer side (testbench or surrounding logic)
//   slave : the encoder itself
interface prio_encoder_rr_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] dout;
  logic             none;
  logic             multi;

  modport master (
    output in_valid, din, out_ready,
    input  in_ready, out_valid, dout, none, multi
  );

  modport slave (
    input  in_valid, din, out_ready,
    output in_ready, out_valid, dout, none, multi
  );

endinterface

// File: rtl/prio_encoder_rr_find.sv
// prio_encoder_rr_find: combinational rotate-and-search core (prio_find).
//   i_vec   - request vector
//   i_start - first index examined; search runs downward, wrapping 0 -> WIDTH-1
//   o_idx   - index of the first set bit found (0 when none)
//   o_found - at least one bit set
//   o_multi - two or more bits set
module prio_encoder_rr_find #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_vec,
  input  logic [IDX_W-1:0] i_start,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_found,
  output logic             o_multi
);

  always_comb begin
    int               pos;
    logic [IDX_W-1:0] sel;
    o_idx   = '0;
    o_found = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      // Wrap modulo WIDTH, not 2**IDX_W, so non-power-of-two widths never visit ghost bits.
      if (i <= int'(i_start)) pos = int'(i_start) - i;
      else                    pos = int'(i_start) + int'(WIDTH) - i;
      sel = pos[IDX_W-1:0];
      if (!o_found && i_vec[sel]) begin
        o_found = 1'b1;
        o_idx   = sel;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign o_multi = |(i_vec & (i_vec - WIDTH'(1)));

endmodule

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: registered WIDTH-bit priority encoder with valid/ready handshakes.
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - slave side of prio_encoder_rr_if (din stream in, dout/none/multi stream out)
// RR_MODE selects fixed (highest bit wins) or round-robin priority. The output stage is a
// single-entry register; in_ready is combinational so accept and drain can overlap.
module prio_encoder_rr
  import prio_encoder_rr_pkg::*;
#(
  parameter  int unsigned WIDTH   = 8,
  parameter  int unsigned RR_MODE = PRIO_FIXED,
  localparam int unsigned IDX_W   = $clog2(WIDTH)
) (
  input logic               clk,
  input logic               rst_n,
  prio_encoder_rr_if.slave  bus
);

  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(WIDTH - 1);

  logic             r_out_valid;
  logic [IDX_W-1:0] r_dout;
  logic             r_none;
  logic             r_multi;
  logic [IDX_W-1:0] r_ptr;

  logic             w_in_ready;
  logic             w_accept;
  logic [IDX_W-1:0] w_start;
  logic [IDX_W-1:0] w_idx;
  logic             w_found;
  logic             w_multi;

  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;

  // In fixed mode the start index folds to the constant WIDTH-1 and r_ptr drops out.
  assign w_start = (RR_MODE == PRIO_RR) ? r_ptr : PTR_INIT;

  prio_encoder_rr_find #(
    .WIDTH (WIDTH)
  ) u_find (
    .i_vec   (bus.din),
    .i_start (w_start),
    .o_idx   (w_idx),
    .o_found (w_found),
    .o_multi (w_multi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_none      <= 1'b0;
      r_multi     <= 1'b0;
      r_ptr       <= PTR_INIT;
    end else begin
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_dout      <= w_idx;
        r_none      <= !w_found;
        r_multi     <= w_multi;
        // Next search begins just below the winner; an empty vector leaves the pointer alone.
        if (RR_MODE == PRIO_RR && w_found) begin
          r_ptr <= (w_idx == '0) ? PTR_INIT : w_idx - IDX_W'(1);
        end
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.dout      = r_dout;
  assign bus.none      = r_none;
  assign bus.multi     = r_multi;

endmodule
